channel_scan_deserializer: RTL and testbench

Scan controller and deserializer around the 4:1 channel mux in the digital signal splitter. It drives the mux select, steps through the four input channels once per cycle, and samples the selected bit. Each channel's bits are shifted into its own word. After WORD_W full scans, all four words go to a single-entry output register with a valid/ready handshake.

---
 rtl/channel_scan_deserializer.sv | 91 +++++++++
 tb/tb_channel_scan_deserializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/channel_scan_deserializer.sv
// rtl/channel_scan_deserializer.sv - 4:1 channel mux scan controller and per-channel deserializer
// Drives the mux select and collects each channel's bits into its own word, then presents complete frames.
module channel_scan_deserializer #(
  parameter int WORD_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  restart_i,
  output logic [1:0]            sel_o,
  input  logic                  mux_in_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [4*WORD_W-1:0]   out_data_o,
  output logic                  overflow_o,
  input  logic                  clear_ovf_i,
  output logic                  busy_o
);

  localparam int CW = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);

  typedef enum logic {EMPTY, FULL} ostate_e;

  ostate_e                  state_q, state_d;
  logic [1:0]               sel_q, sel_d;
  logic [CW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [3:0][WORD_W-1:0]   shreg_q, shreg_d;
  logic [4*WORD_W-1:0]      data_q, data_d;
  logic                     ovf_q, ovf_d;
  logic                     frame_done, handshake, ovf_set;

  always_comb begin
    sel_d      = sel_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    state_d    = state_q;
    data_d     = data_q;
    ovf_set    = 1'b0;
    frame_done = en_i && !restart_i && (sel_q == 2'd3) && (bit_cnt_q == LAST_BIT);
    handshake  = (state_q == FULL) && out_ready_i;

    if (restart_i) begin
      sel_d     = 2'd0;
      bit_cnt_d = '0;
      shreg_d   = '0;
    end else if (en_i) begin
      shreg_d[sel_q] = {shreg_q[sel_q][WORD_W-2:0], mux_in_i};
      sel_d          = sel_q + 2'd1;
      if (sel_q == 2'd3)
        bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CW'(1);
    end

    // The completed frame includes the bit sampled in the completing cycle.
    if (frame_done && ((state_q == EMPTY) || out_ready_i)) begin
      data_d  = shreg_d;
      state_d = FULL;
    end else if (frame_done) begin
      ovf_set = 1'b1;
    end else if (handshake) begin
      state_d = EMPTY;
    end

    ovf_d = ovf_set || (ovf_q && !clear_ovf_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= EMPTY;
      sel_q     <= 2'd0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign sel_o       = sel_q;
  assign out_valid_o = (state_q == FULL);
  assign out_data_o  = data_q;
  assign overflow_o  = ovf_q;
  assign busy_o      = (sel_q != 2'd0) || (bit_cnt_q != '0);

endmodule

// File: tb/tb_channel_scan_deserializer.sv
// tb/tb_channel_scan_deserializer.sv - self-checking bench for channel_scan_deserializer
// A model mux feeds known channel words; a scoreboard queue holds the frame expected in the output register.
module tb_channel_scan_deserializer;

  localparam int W = 8;

  logic              clk = 1'b0;
  logic              rst, en, restart, mux_in, out_ready, clear_ovf;
  logic [1:0]        sel;
  logic              out_valid, overflow, busy;
  logic [4*W-1:0]    out_data;

  channel_scan_deserializer #(.WORD_W(W)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .restart_i(restart), .sel_o(sel),
    .mux_in_i(mux_in), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .overflow_o(overflow), .clear_ovf_i(clear_ovf), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] ch;
    logic [31:0]     exp;
  } vec_t;

  vec_t            tbl [3];
  logic [3:0][7:0] cur_words;
  logic [31:0]     cur_exp;
  logic [31:0]     sb_q [$];
  int              m_sel, m_bit, cyc, first_valid;
  bit              m_valid, m_ovf, seen_valid;
  int              checks = 0, errors = 0;

  always_comb mux_in = cur_words[sel][7 - m_bit];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_bit = 0; m_valid = 0; m_ovf = 0;
    sb_q.delete();
  endtask

  // One clock: compare against the model, advance the model, step past the edge.
  task automatic cycle();
    bit done, hs, set;
    int n_sel, n_bit;
    chk("sel", 32'(sel), 32'(m_sel));
    chk("busy", 32'(busy), 32'((m_sel != 0) || (m_bit != 0)));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (m_valid && sb_q.size() > 0) chk("out_data", out_data, sb_q[0]);
    done = en && !restart && m_sel == 3 && m_bit == W - 1;
    hs = m_valid && out_ready;
    set = 0;
    if (hs) void'(sb_q.pop_front());
    if (done && (!m_valid || out_ready)) begin
      sb_q.push_back(cur_exp);
      m_valid = 1;
    end else if (done) begin
      set = 1;
    end else if (hs) begin
      m_valid = 0;
    end
    m_ovf = set ? 1'b1 : (clear_ovf ? 1'b0 : m_ovf);
    n_sel = m_sel; n_bit = m_bit;
    if (restart) begin
      n_sel = 0; n_bit = 0;
    end else if (en) begin
      n_sel = (m_sel + 1) % 4;
      if (m_sel == 3) n_bit = (m_bit + 1) % W;
    end
    @(posedge clk); #1;
    m_sel = n_sel; m_bit = n_bit;
    cyc++;
    if (!seen_valid && out_valid) begin
      seen_valid = 1;
      first_valid = cyc;
    end
  endtask

  task automatic idle(input logic rdy, input logic clr);
    en = 0; out_ready = rdy; clear_ovf = clr;
    cycle();
    clear_ovf = 0;
  endtask

  task automatic run_frame(input logic [3:0][7:0] words, input logic [31:0] exp,
                           input logic rb, input logic rl, input bit rand_en, input logic cl_last);
    bit fin = 0;
    int guard = 0;
    cur_words = words; cur_exp = exp;
    while (!fin && guard < 400) begin
      en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (en && m_sel == 3 && m_bit == W - 1) begin
        out_ready = rl; clear_ovf = cl_last; fin = 1;
      end else begin
        out_ready = rb; clear_ovf = 0;
      end
      cycle();
      guard++;
    end
    clear_ovf = 0;
    if (!fin) chk("frame_timeout", 32'(guard), 32'd0);
  endtask

  initial begin
    tbl[0] = '{ch: {8'h00, 8'hFF, 8'h3C, 8'hA5}, exp: 32'h00FF3CA5};
    tbl[1] = '{ch: {8'h78, 8'h56, 8'h34, 8'h12}, exp: 32'h78563412};
    tbl[2] = '{ch: {8'h7E, 8'hC3, 8'h80, 8'h01}, exp: 32'h7EC38001};

    rst = 1; en = 0; restart = 0; out_ready = 0; clear_ovf = 0;
    cur_words = '0; cur_exp = '0; seen_valid = 0; first_valid = 0; cyc = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 0;

    for (int i = 0; i < 3; i++) begin
      run_frame(tbl[i].ch, tbl[i].exp, 1'b1, 1'b1, 0, 1'b0);
      chk("tbl_valid", 32'(out_valid), 1);
      chk("tbl_data", out_data, tbl[i].exp);
      if (i == 0) chk("first_valid_cycle", 32'(first_valid), 32);
    end
    idle(1'b1, 1'b0);

    // Backpressure: first frame held, second dropped, then one handshake.
    run_frame({8'h11, 8'h22, 8'h33, 8'h44}, 32'h11223344, 1'b0, 1'b0, 0, 1'b0);
    run_frame({8'hDE, 8'hAD, 8'hBE, 8'hEF}, 32'hDEADBEEF, 1'b0, 1'b0, 0, 1'b0);
    chk("bp_ovf", 32'(overflow), 1);
    chk("bp_held", out_data, 32'h11223344);
    idle(1'b1, 1'b0);
    chk("bp_drained", 32'(out_valid), 0);
    run_frame({8'hC0, 8'hFF, 8'hEE, 8'h01}, 32'hC0FFEE01, 1'b1, 1'b1, 0, 1'b0);
    chk("bp_third", out_data, 32'hC0FFEE01);
    idle(1'b1, 1'b0);

    idle(1'b0, 1'b1);
    chk("clear_alone", 32'(overflow), 0);

    // Back-to-back: ready only on the completion cycle of the second frame.
    run_frame({8'hAA, 8'h55, 8'hAA, 8'h55}, 32'hAA55AA55, 1'b0, 1'b0, 0, 1'b0);
    run_frame({8'h0F, 8'hF0, 8'h5A, 8'hA5}, 32'h0FF05AA5, 1'b0, 1'b1, 0, 1'b0);
    chk("b2b_valid", 32'(out_valid), 1);
    chk("b2b_data", out_data, 32'h0FF05AA5);
    chk("b2b_ovf", 32'(overflow), 0);
    idle(1'b1, 1'b0);

    run_frame(tbl[0].ch, tbl[0].exp, 1'b1, 1'b1, 1, 1'b0);
    chk("gap_data", out_data, 32'h00FF3CA5);
    idle(1'b1, 1'b0);

    // Restart at bit 3, channel 2 after junk samples.
    cur_words = {8'hFF, 8'hFF, 8'hFF, 8'hFF}; en = 1; out_ready = 1;
    for (int g = 0; g < 100 && !(m_bit == 3 && m_sel == 2); g++) cycle();
    chk("rs_pos", 32'(sel), 2);
    restart = 1;
    cycle();
    restart = 0;
    chk("rs_sel", 32'(sel), 0);
    chk("rs_busy", 32'(busy), 0);
    run_frame({8'h96, 8'h69, 8'h0C, 8'h30}, 32'h96690C30, 1'b1, 1'b1, 0, 1'b0);
    chk("rs_data", out_data, 32'h96690C30);

    // Overflow set coincident with clear: set wins.
    run_frame({8'h12, 8'h12, 8'h12, 8'h12}, 32'h12121212, 1'b0, 1'b0, 0, 1'b1);
    chk("clr_vs_set", 32'(overflow), 1);
    chk("clr_vs_set_held", out_data, 32'h96690C30);

    // Async reset mid-frame with out_valid and overflow both high.
    en = 1; out_ready = 0;
    repeat (5) cycle();
    chk("pre_rst_valid", 32'(out_valid), 1);
    chk("pre_rst_busy", 32'(busy), 1);
    @(negedge clk); #1;
    rst = 1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_data", out_data, 0);
    chk("arst_sel", 32'(sel), 0);
    chk("arst_busy", 32'(busy), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    run_frame(tbl[1].ch, tbl[1].exp, 1'b1, 1'b1, 0, 1'b0);
    chk("post_rst_data", out_data, 32'h78563412);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
